// File: rtl/term_pair_scheduler.sv
// term_pair_scheduler: serialises every per-lane (activation bit, weight bit)
// term pair of one sign-magnitude group into one beat per cycle.
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   in_valid/in_ready group handshake (act_mag, act_sign, wgt_mag, wgt_sign)
//   out_valid/out_ready beat handshake
//   in_applied, t0, t1, s0, s1, out_last  beat payload in core bus layout
module term_pair_scheduler #(
    parameter int N     = 16,
    parameter int MAG_W = 8,
    parameter int TW    = $clog2(MAG_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*MAG_W-1:0] act_mag,
    input  logic [N-1:0]       act_sign,
    input  logic [N*MAG_W-1:0] wgt_mag,
    input  logic [N-1:0]       wgt_sign,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       in_applied,
    output logic [N*TW-1:0]    t0,
    output logic [N*TW-1:0]    t1,
    output logic [N-1:0]       s0,
    output logic [N-1:0]       s1,
    output logic               out_last
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e state_q, state_d;

    logic [MAG_W-1:0] a_rem_q [N];
    logic [MAG_W-1:0] a_rem_d [N];
    logic [MAG_W-1:0] w_rem_q [N];
    logic [MAG_W-1:0] w_rem_d [N];
    logic [MAG_W-1:0] w_mag_q [N];
    logic [MAG_W-1:0] w_mag_d [N];
    logic [N-1:0]     as_q, as_d;
    logic [N-1:0]     ws_q, ws_d;

    logic [N-1:0] active;
    logic [N-1:0] final_pair;
    logic         grp_last;
    logic         fire;
    logic         accept;

    function automatic logic [TW-1:0] lsb_idx(input logic [MAG_W-1:0] x);
        logic [TW-1:0] idx;
        idx = '0;
        for (int i = MAG_W - 1; i >= 0; i--) begin
            if (x[i]) idx = TW'(i);
        end
        return idx;
    endfunction

    function automatic logic one_hot(input logic [MAG_W-1:0] x);
        return (x != '0) && ((x & (x - MAG_W'(1))) == '0);
    endfunction

    // A lane is live while activation bits remain; w_rem is never zero
    // for a live lane because it reloads from w_mag.
    always_comb begin
        active     = '0;
        final_pair = '0;
        for (int k = 0; k < N; k++) begin
            active[k]     = (a_rem_q[k] != '0) && (w_mag_q[k] != '0);
            final_pair[k] = one_hot(a_rem_q[k]) && one_hot(w_rem_q[k]);
        end
    end

    // Also true when no lane is active, giving empty groups one beat.
    assign grp_last = ((active & ~final_pair) == '0);
    assign fire     = (state_q == RUN) && out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN:  if (fire && grp_last && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            a_rem_d[k] = a_rem_q[k];
            w_rem_d[k] = w_rem_q[k];
            w_mag_d[k] = w_mag_q[k];
        end
        as_d = as_q;
        ws_d = ws_q;
        if (accept) begin
            for (int k = 0; k < N; k++) begin
                a_rem_d[k] = act_mag[k*MAG_W +: MAG_W];
                w_rem_d[k] = wgt_mag[k*MAG_W +: MAG_W];
                w_mag_d[k] = wgt_mag[k*MAG_W +: MAG_W];
            end
            as_d = act_sign;
            ws_d = wgt_sign;
        end else if (fire) begin
            for (int k = 0; k < N; k++) begin
                if (active[k]) begin
                    // Inner loop walks weight bits; wrapping it steps
                    // the outer activation bit.
                    if (one_hot(w_rem_q[k])) begin
                        a_rem_d[k] = a_rem_q[k] & (a_rem_q[k] - MAG_W'(1));
                        w_rem_d[k] = w_mag_q[k];
                    end else begin
                        w_rem_d[k] = w_rem_q[k] & (w_rem_q[k] - MAG_W'(1));
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                a_rem_q[k] <= '0;
                w_rem_q[k] <= '0;
                w_mag_q[k] <= '0;
            end
            as_q <= '0;
            ws_q <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                a_rem_q[k] <= a_rem_d[k];
                w_rem_q[k] <= w_rem_d[k];
                w_mag_q[k] <= w_mag_d[k];
            end
            as_q <= as_d;
            ws_q <= ws_d;
        end
    end

    always_comb begin
        out_valid  = (state_q == RUN);
        out_last   = out_valid && grp_last;
        in_ready   = !out_valid || (out_ready && grp_last);
        in_applied = '0;
        t0         = '0;
        t1         = '0;
        s0         = '0;
        s1         = '0;
        if (out_valid) begin
            for (int k = 0; k < N; k++) begin
                if (active[k]) begin
                    in_applied[k]     = 1'b1;
                    t0[k*TW +: TW]    = lsb_idx(a_rem_q[k]);
                    t1[k*TW +: TW]    = lsb_idx(w_rem_q[k]);
                    s0[k]             = as_q[k];
                    s1[k]             = ws_q[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_term_pair_scheduler.sv
// tb_term_pair_scheduler: directed and randomised-ready bench for
// term_pair_scheduler against a pair-list reference model.
module tb_term_pair_scheduler;

    localparam int N  = 16;
    localparam int MW = 8;
    localparam int TW = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N*MW-1:0] act_mag = '0;
    logic [N-1:0]    act_sign = '0;
    logic [N*MW-1:0] wgt_mag = '0;
    logic [N-1:0]    wgt_sign = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [N-1:0]    in_applied;
    logic [N*TW-1:0] t0;
    logic [N*TW-1:0] t1;
    logic [N-1:0]    s0;
    logic [N-1:0]    s1;
    logic            out_last;

    term_pair_scheduler #(.N(N), .MAG_W(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .act_mag(act_mag), .act_sign(act_sign),
        .wgt_mag(wgt_mag), .wgt_sign(wgt_sign),
        .out_valid(out_valid), .out_ready(out_ready),
        .in_applied(in_applied), .t0(t0), .t1(t1),
        .s0(s0), .s1(s1), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]    app;
        logic [N*TW-1:0] t0;
        logic [N*TW-1:0] t1;
        logic [N-1:0]    s0;
        logic [N-1:0]    s1;
        logic            last;
    } beat_t;

    beat_t  exp_q[$];
    beat_t  log_q[$];
    longint dot_q[$];
    int     pass_cnt = 0;
    int     tot_cnt = 0;
    bit     rnd_ready = 1'b0;

    task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
        tot_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    endtask

    function automatic int popc(input logic [MW-1:0] x);
        int c = 0;
        for (int i = 0; i < MW; i++) c += int'(x[i]);
        return c;
    endfunction

    function automatic int nth_bit(input logic [MW-1:0] x, input int n);
        int c = 0;
        for (int i = 0; i < MW; i++) begin
            if (x[i]) begin
                if (c == n) return i;
                c++;
            end
        end
        return 0;
    endfunction

    // Expected beats: lane k lists its pairs in (a bit, w bit) order; beat b
    // takes pair b of every lane that still has one.
    task automatic model_group(input logic [N*MW-1:0] am, input logic [N*MW-1:0] wm,
                               input logic [N-1:0] as, input logic [N-1:0] ws);
        int          cnt[N];
        int          nb;
        int          pw;
        longint      dot;
        longint      p;
        beat_t       e;
        logic [MW-1:0] a;
        logic [MW-1:0] w;
        nb  = 1;
        dot = 0;
        for (int k = 0; k < N; k++) begin
            a = am[k*MW +: MW];
            w = wm[k*MW +: MW];
            cnt[k] = popc(a) * popc(w);
            if (cnt[k] > nb) nb = cnt[k];
            p = longint'(a) * longint'(w);
            dot += (as[k] ^ ws[k]) ? -p : p;
        end
        for (int b = 0; b < nb; b++) begin
            e = '0;
            for (int k = 0; k < N; k++) begin
                if (b < cnt[k]) begin
                    a  = am[k*MW +: MW];
                    w  = wm[k*MW +: MW];
                    pw = popc(w);
                    e.app[k] = 1'b1;
                    e.t0[k*TW +: TW] = TW'(nth_bit(a, b / pw));
                    e.t1[k*TW +: TW] = TW'(nth_bit(w, b % pw));
                    e.s0[k] = as[k];
                    e.s1[k] = ws[k];
                end
            end
            e.last = (b == nb - 1);
            exp_q.push_back(e);
        end
        dot_q.push_back(dot);
    endtask

    // Compare process: every negedge while a beat is presented.
    initial begin
        beat_t  cur;
        beat_t  prev;
        bit     stall;
        longint acc;
        longint term;
        longint d;
        stall = 1'b0;
        acc   = 0;
        prev  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                dot_q.delete();
                stall = 1'b0;
                acc   = 0;
                continue;
            end
            cur.app  = in_applied;
            cur.t0   = t0;
            cur.t1   = t1;
            cur.s0   = s0;
            cur.s1   = s1;
            cur.last = out_last;
            if (out_valid) begin
                if (stall) chk("stall_hold", cur, prev);
                if (exp_q.size() == 0) begin
                    tot_cnt++;
                    $display("FAIL unexpected_beat got app=%0h exp none", cur.app);
                end else begin
                    chk("beat", cur, exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        log_q.push_back(cur);
                        for (int k = 0; k < N; k++) begin
                            if (cur.app[k]) begin
                                term = longint'(1) << (int'(cur.t0[k*TW +: TW]) + int'(cur.t1[k*TW +: TW]));
                                acc += (cur.s0[k] ^ cur.s1[k]) ? -term : term;
                            end
                        end
                        if (cur.last && dot_q.size() > 0) begin
                            d = dot_q.pop_front();
                            chk("dot_product", acc, d);
                            acc = 0;
                        end
                    end
                end
                stall = !out_ready;
                prev  = cur;
            end else begin
                stall = 1'b0;
            end
            if (in_valid && in_ready) model_group(act_mag, wgt_mag, act_sign, wgt_sign);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send(input logic [N*MW-1:0] am, input logic [N*MW-1:0] wm,
                        input logic [N-1:0] as, input logic [N-1:0] ws);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        act_mag  = am;
        wgt_mag  = wm;
        act_sign = as;
        wgt_sign = ws;
        in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) begin
            tot_cnt++;
            $display("FAIL accept_timeout got in_ready=0 exp 1");
        end
    endtask

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        tot_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s_drain got pending=%0d exp 0", nm, exp_q.size());
    endtask

    initial begin
        logic [N*MW-1:0] am;
        logic [N*MW-1:0] wm;
        logic [N-1:0]    as;
        logic [N-1:0]    ws;
        logic [24:0]     exp1 [4];
        logic [24:0]     got1;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_in_applied", in_applied, 0);
        chk("rst_t0_t1", {t0, t1}, 0);
        chk("rst_s0_s1", {s0, s1}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);

        // Single lane 5 x 3, weight negative.
        am = '0; wm = '0; as = '0; ws = '0;
        am[7:0] = 8'h05;
        wm[7:0] = 8'h03;
        ws[0]   = 1'b1;
        log_q.delete();
        send(am, wm, as, ws);
        wait_idle("single");
        chk("single_beats", log_q.size(), 4);
        exp1[0] = {16'h0001, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0};
        exp1[1] = {16'h0001, 3'd0, 3'd1, 1'b0, 1'b1, 1'b0};
        exp1[2] = {16'h0001, 3'd2, 3'd0, 1'b0, 1'b1, 1'b0};
        exp1[3] = {16'h0001, 3'd2, 3'd1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            got1 = {log_q[i].app, log_q[i].t0[2:0], log_q[i].t1[2:0],
                    log_q[i].s0[0], log_q[i].s1[0], log_q[i].last};
            chk($sformatf("single_beat%0d", i), got1, exp1[i]);
        end

        // Empty group.
        log_q.delete();
        send('0, '0, '0, '0);
        wait_idle("empty");
        chk("empty_beats", log_q.size(), 1);
        chk("empty_app", log_q[0].app, 0);
        chk("empty_last", log_q[0].last, 1);
        chk("empty_in_ready", in_ready, 1);

        // Full group, every lane 0xFF.
        log_q.delete();
        send('1, '1, '0, '0);
        wait_idle("full");
        chk("full_beats", log_q.size(), 64);
        chk("full_app0", log_q[0].app, 16'hFFFF);
        chk("full_b9_l0", {log_q[9].t0[2:0], log_q[9].t1[2:0]}, {3'd1, 3'd1});
        chk("full_b13_l0", {log_q[13].t0[2:0], log_q[13].t1[2:0]}, {3'd1, 3'd5});
        chk("full_b9_l15", log_q[9].t0[47:45], 3'd1);
        chk("full_b62_last", log_q[62].last, 0);
        chk("full_b63_last", log_q[63].last, 1);

        // Uneven lanes.
        am = '0; wm = '0; as = '0; ws = '0;
        am[7:0]   = 8'h01; wm[7:0]   = 8'h10;
        am[15:8]  = 8'h03; wm[15:8]  = 8'h06;
        am[23:16] = 8'h80; wm[23:16] = 8'h00;
        log_q.delete();
        send(am, wm, as, ws);
        wait_idle("uneven");
        chk("uneven_beats", log_q.size(), 4);
        chk("uneven_app", {log_q[0].app, log_q[1].app, log_q[2].app, log_q[3].app},
            {16'h0003, 16'h0002, 16'h0002, 16'h0002});
        chk("uneven_l0_t1", log_q[0].t1[2:0], 3'd4);
        chk("uneven_l1_b3", {log_q[3].t0[5:3], log_q[3].t1[5:3]}, {3'd1, 3'd2});

        // Random groups under random back-pressure.
        rnd_ready = 1'b1;
        for (int g = 0; g < 25; g++) begin
            for (int k = 0; k < N; k++) begin
                am[k*MW +: MW] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                wm[k*MW +: MW] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            end
            as = 16'($urandom);
            ws = 16'($urandom);
            send(am, wm, as, ws);
        end
        wait_idle("random");
        rnd_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Back-to-back: B must appear the cycle after A's last fire.
        am = '0; wm = '0;
        am[7:0] = 8'h03; wm[7:0] = 8'h03;
        send(am, wm, '0, '0);
        am = '0; wm = '0;
        am[15:8] = 8'h01; wm[15:8] = 8'h01;
        send(am, wm, '0, 16'h0002);
        @(negedge clk);
        chk("b2b_valid", out_valid, 1);
        chk("b2b_app", in_applied, 16'h0002);
        chk("b2b_last", out_last, 1);
        wait_idle("b2b");

        // Reset in the middle of a long group.
        send('1, '1, '0, '0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_app", in_applied, 0);
        chk("midrst_last", out_last, 0);
        chk("midrst_t0", t0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_idle", out_valid, 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
